data_mem_ctrl: RTL and testbench

Parametrised next-generation data memory for the Harvard datapath. It replaces the fixed 64-entry, unhandshaked data RAM with configurable width and depth, per-byte write enables, and a valid/ready request/response interface. Reads are registered with back-pressure. Out-of-range accesses are flagged. An optional post-reset clear sequencer zeroes the array. It sits between the execute stage and the data store; the instruction, accumulator and status memories are unaffected.

---
 rtl/data_mem_ctrl.sv | 90 +++++++++
 tb/tb_data_mem_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: parametrised byte-enabled data memory with a valid/ready
// request port, registered read response and an optional post-reset clear.
module data_mem_ctrl #(
    parameter int DW         = 16,
    parameter int AW         = 6,
    parameter int DEPTH      = 64,
    parameter int INIT_CLEAR = 1
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic            REQ_WE,
    input  logic [AW-1:0]   REQ_ADDR,
    input  logic [DW-1:0]   REQ_WDATA,
    input  logic [DW/8-1:0] REQ_BE,
    output logic            RSP_VALID,
    input  logic            RSP_READY,
    output logic [DW-1:0]   RSP_RDATA,
    output logic            RSP_ERR,
    output logic            BUSY
);

    localparam int BW = DW / 8;

    localparam logic [0:0] ST_CLEAR  = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;
    localparam logic [0:0] RST_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;

    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
    localparam logic [AW:0]   LIMIT = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic [0:0]    state;
    logic [AW-1:0] cnt;
    logic          in_range;
    logic          accept;
    logic          wr_acc;
    logic          rd_acc;

    assign in_range  = ({1'b0, REQ_ADDR} < LIMIT);
    assign REQ_READY = (state == ST_RUN) && (!RSP_VALID || RSP_READY);
    assign accept    = REQ_VALID && REQ_READY;
    assign wr_acc    = accept && REQ_WE;
    assign rd_acc    = accept && !REQ_WE;
    assign BUSY      = (state == ST_CLEAR);

    // Clear sequencer: sweep cnt across the array once, then run until reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else if (state == ST_CLEAR) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                state <= ST_RUN;
            end
        end
    end

    // Single write port: clear writes in CLEAR, byte-masked request writes in RUN.
    always_ff @(posedge CLK) begin
        if (state == ST_CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_acc && in_range) begin
            for (int i = 0; i < BW; i++) begin
                if (REQ_BE[i]) begin
                    mem[REQ_ADDR][8*i +: 8] <= REQ_WDATA[8*i +: 8];
                end
            end
        end
    end

    // Response register: load on read accept, retire on consumer handshake.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
            RSP_ERR   <= 1'b0;
        end else if (rd_acc) begin
            RSP_VALID <= 1'b1;
            RSP_RDATA <= in_range ? mem[REQ_ADDR] : '0;
            RSP_ERR   <= !in_range;
        end else if (RSP_VALID && RSP_READY) begin
            RSP_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed table, corner sequences and random traffic
// checked against a word-array reference model of the data memory.
module tb_data_mem_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 6;
    localparam int DEPTH = 48;
    localparam int BW    = DW / 8;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b1;
    logic          REQ_VALID = 1'b0;
    logic          REQ_READY;
    logic          REQ_WE = 1'b0;
    logic [AW-1:0] REQ_ADDR = '0;
    logic [DW-1:0] REQ_WDATA = '0;
    logic [BW-1:0] REQ_BE = '0;
    logic          RSP_VALID;
    logic          RSP_READY = 1'b1;
    logic [DW-1:0] RSP_RDATA;
    logic          RSP_ERR;
    logic          BUSY;

    always #5 CLK = ~CLK;

    data_mem_ctrl #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .INIT_CLEAR(1)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
        .REQ_WDATA(REQ_WDATA), .REQ_BE(REQ_BE),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .BUSY(BUSY)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain word array plus one response slot.
    logic [DW-1:0] ref_mem [DEPTH];
    bit            m_valid;
    logic [DW-1:0] m_rdata;
    bit            m_err;
    int            clear_left;

    typedef struct {
        bit            v;
        bit            we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [BW-1:0] be;
        bit            rr;
        bit            e_rdy;
        bit            e_vld;
        logic [DW-1:0] e_dat;
        bit            e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid    = 0;
        m_rdata    = '0;
        m_err      = 0;
        clear_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    // One clock: drive at negedge, check ready/busy, step model, check outputs.
    task automatic cycle(input bit v, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [BW-1:0] be,
                         input bit rr, output bit rdy_seen);
        bit exp_rdy;
        bit acc;
        REQ_VALID = v;
        REQ_WE    = we;
        REQ_ADDR  = a;
        REQ_WDATA = wd;
        REQ_BE    = be;
        RSP_READY = rr;
        #1;
        exp_rdy  = (clear_left == 0) && (!m_valid || rr);
        rdy_seen = REQ_READY;
        chk("req_ready", REQ_READY, exp_rdy);
        chk("busy", BUSY, clear_left != 0);
        acc = v && exp_rdy;
        @(posedge CLK);
        if (clear_left > 0) clear_left--;
        if (acc && !we) begin
            m_valid = 1;
            if (int'(a) < DEPTH) begin
                m_rdata = ref_mem[a];
                m_err   = 0;
            end else begin
                m_rdata = '0;
                m_err   = 1;
            end
        end else if (m_valid && rr) begin
            m_valid = 0;
        end
        if (acc && we && int'(a) < DEPTH) begin
            for (int i = 0; i < BW; i++)
                if (be[i]) ref_mem[a][8*i +: 8] = wd[8*i +: 8];
        end
        @(negedge CLK);
        chk("rsp_valid", RSP_VALID, m_valid);
        chk("rsp_rdata", RSP_RDATA, m_rdata);
        chk("rsp_err", RSP_ERR, m_err);
    endtask

    // Async reset: outputs must drop without waiting for a clock edge.
    task automatic do_reset();
        RST_N     = 1'b0;
        REQ_VALID = 1'b0;
        #1;
        chk("rst_valid", RSP_VALID, 0);
        chk("rst_rdata", RSP_RDATA, 0);
        chk("rst_err", RSP_ERR, 0);
        chk("rst_busy", BUSY, 1);
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic count_clear(input string name);
        int  n;
        bit  r;
        n = 0;
        while (BUSY && n < 200) begin
            cycle(1, 0, 6'd47, '0, '0, 1, r);
            n++;
        end
        chk(name, n, DEPTH);
    endtask

    initial begin
        bit r;
        int pre;

        tbl.push_back('{1, 1, 6'd5,  16'hBEEF, 2'b11, 1, 1, 0, 16'h0000, 0});
        tbl.push_back('{1, 0, 6'd5,  16'h0000, 2'b00, 1, 1, 1, 16'hBEEF, 0});
        tbl.push_back('{1, 1, 6'd5,  16'h1234, 2'b01, 1, 1, 0, 16'hBEEF, 0});
        tbl.push_back('{1, 0, 6'd5,  16'h0000, 2'b00, 1, 1, 1, 16'hBE34, 0});
        tbl.push_back('{1, 1, 6'd1,  16'h0011, 2'b11, 1, 1, 0, 16'hBE34, 0});
        tbl.push_back('{1, 1, 6'd2,  16'h0022, 2'b11, 1, 1, 0, 16'hBE34, 0});
        tbl.push_back('{1, 1, 6'd3,  16'h0033, 2'b11, 1, 1, 0, 16'hBE34, 0});
        tbl.push_back('{1, 0, 6'd1,  16'h0000, 2'b00, 1, 1, 1, 16'h0011, 0});
        tbl.push_back('{1, 0, 6'd2,  16'h0000, 2'b00, 1, 1, 1, 16'h0022, 0});
        tbl.push_back('{1, 0, 6'd3,  16'h0000, 2'b00, 1, 1, 1, 16'h0033, 0});
        tbl.push_back('{0, 0, 6'd0,  16'h0000, 2'b00, 1, 1, 0, 16'h0033, 0});
        tbl.push_back('{1, 1, 6'd50, 16'hAAAA, 2'b11, 1, 1, 0, 16'h0033, 0});
        tbl.push_back('{1, 0, 6'd50, 16'h0000, 2'b00, 1, 1, 1, 16'h0000, 1});
        tbl.push_back('{1, 0, 6'd2,  16'h0000, 2'b00, 1, 1, 1, 16'h0022, 0});
        tbl.push_back('{1, 1, 6'd7,  16'hFFFF, 2'b00, 1, 1, 0, 16'h0022, 0});
        tbl.push_back('{1, 0, 6'd7,  16'h0000, 2'b00, 1, 1, 1, 16'h0000, 0});
        tbl.push_back('{0, 0, 6'd0,  16'h0000, 2'b00, 1, 1, 0, 16'h0000, 0});
        tbl.push_back('{1, 1, 6'd5,  16'h7700, 2'b10, 1, 1, 0, 16'h0000, 0});
        tbl.push_back('{1, 0, 6'd5,  16'h0000, 2'b00, 1, 1, 1, 16'h7734, 0});
        tbl.push_back('{0, 0, 6'd0,  16'h0000, 2'b00, 1, 1, 0, 16'h7734, 0});

        @(negedge CLK);
        do_reset();

        // Clear window with a request held, then first read from RUN.
        count_clear("clear_cycles");
        cycle(1, 0, 6'd47, '0, '0, 1, r);
        chk("first_rd_rdy", r, 1);
        chk("first_rd_vld", RSP_VALID, 1);
        chk("first_rd_dat", RSP_RDATA, 16'h0000);
        chk("first_rd_err", RSP_ERR, 0);

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].be,
                  tbl[i].rr, r);
            chk($sformatf("tbl%0d_rdy", i), r, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_vld", i), RSP_VALID, tbl[i].e_vld);
            chk($sformatf("tbl%0d_dat", i), RSP_RDATA, tbl[i].e_dat);
            chk($sformatf("tbl%0d_err", i), RSP_ERR, tbl[i].e_err);
        end

        // Back-pressure: response held, queued read waits, then goes.
        cycle(1, 0, 6'd2, '0, '0, 0, r);
        chk("bp_first_rdy", r, 1);
        for (int k = 0; k < 4; k++) begin
            cycle(1, 0, 6'd3, '0, '0, 0, r);
            chk("bp_hold_rdy", r, 0);
            chk("bp_hold_vld", RSP_VALID, 1);
            chk("bp_hold_dat", RSP_RDATA, 16'h0022);
        end
        cycle(1, 0, 6'd3, '0, '0, 1, r);
        chk("bp_release_rdy", r, 1);
        chk("bp_release_dat", RSP_RDATA, 16'h0033);
        cycle(0, 0, '0, '0, '0, 1, r);

        // Random traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            cycle(bit'($urandom_range(0, 3) != 0),
                  bit'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 63)),
                  DW'($urandom),
                  BW'($urandom),
                  bit'($urandom_range(0, 3) != 0), r);
        end
        cycle(0, 0, '0, '0, '0, 1, r);

        // Reset mid-clear restarts the full clear.
        do_reset();
        for (int k = 0; k < 20; k++) cycle(0, 0, '0, '0, '0, 1, r);
        do_reset();
        count_clear("reclear_cycles");
        cycle(1, 0, 6'd5, '0, '0, 1, r);
        chk("reclear_rd5", RSP_RDATA, 16'h0000);

        // Reset with a response pending drops it.
        cycle(1, 1, 6'd5, 16'h5A5A, 2'b11, 1, r);
        cycle(1, 0, 6'd5, '0, '0, 0, r);
        pre = int'(RSP_RDATA);
        chk("pend_dat", pre, 32'h5A5A);
        do_reset();
        count_clear("pend_clear_cycles");
        cycle(1, 0, 6'd5, '0, '0, 1, r);
        chk("post_rst_rd5_vld", RSP_VALID, 1);
        chk("post_rst_rd5_dat", RSP_RDATA, 16'h0000);
        cycle(0, 0, '0, '0, '0, 1, r);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
